tap_controller: RTL and testbench
=================================

TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, meaning instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001, meaning the device ID shifted out under IDCODE (bit 0 SHALL be 1).
REQ-003 SHALL have port TCK, input, 1, the single clock; all state changes on posedge TCK.
REQ-004 SHALL have port TRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port TMS, input, 1, mode select.
REQ-006 SHALL have port TDI, input, 1, serial data in.
REQ-007 SHALL have port TDO, output, 1, serial data out.
REQ-008 SHALL have port BIST_DATA, input, 16, BIST result/PC word captured for READBIST.
REQ-009 SHALL have port TLR, output, 1, high while in Test-Logic-Reset.
REQ-010 SHALL have port UPDATEDR, output, 1, high for exactly the Update-DR cycle.
REQ-011 SHALL have port GETTEST_SELECT, output, 1, high while IR holds GETTEST.
REQ-012 SHALL have port RUNBIST_SELECT, output, 1, high while IR holds RUNBIST.
REQ-013 SHALL have port BSR, output, 10, parallel test-vector word ({config[4:0], check[4:0]}).

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM, transitions on TMS at posedge TCK.
REQ-015 SHALL encode opcodes: BYPASS=4'hF, IDCODE=4'h1, GETTEST=4'h2, RUNBIST=4'h3, READBIST=4'h4; any other opcode SHALL behave as BYPASS.
REQ-016 Capture-IR SHALL load IR shift register with 4'b0001; Shift-IR shifts LSB out on TDO, TDI into MSB.
REQ-017 Update-IR SHALL copy IR shift register to the active IR; selects change on the following cycle.
REQ-018 DR selection: BYPASS/RUNBIST/unknown -> 1-bit bypass (captures 0); IDCODE -> 32-bit (captures IDCODE_VALUE); GETTEST -> 10-bit (captures current BSR); READBIST -> 16-bit (captures BIST_DATA).
REQ-019 Shift-DR SHALL shift the selected DR LSB-first, TDI into its MSB, one bit per TCK.
REQ-020 TDO SHALL equal the LSB of the IR or selected DR in Shift-IR/Shift-DR, else 0 (combinational from registers).
REQ-021 BSR SHALL load from the GETTEST shift register on the transition into Update-DR, only when IR=GETTEST, so BSR is stable and new during the UPDATEDR-high cycle.
REQ-022 UPDATEDR SHALL be asserted for one TCK per Update-DR visit regardless of instruction.
REQ-023 Five consecutive TMS=1 cycles from any state SHALL reach Test-Logic-Reset.
REQ-024 Entering Test-Logic-Reset via TMS SHALL reset IR to its reset value; BSR SHALL be retained.
REQ-025 Pause-DR/Pause-IR SHALL hold shift registers unchanged.

Reset
REQ-026 TRST low SHALL asynchronously force FSM=Test-Logic-Reset, IR=IDCODE (BYPASS without IDCODE_EN), BSR=0, all shift registers=0.
REQ-027 Reset values: TLR=1, UPDATEDR=0, GETTEST_SELECT=0, RUNBIST_SELECT=0, TDO=0.
REQ-028 TRST mid-shift SHALL abort the scan; no partial BSR update.

Configuration
REQ-029 Macro TAP_IDCODE_EN defined: IDCODE opcode and 32-bit ID register present; reset IR=IDCODE.
REQ-030 Macro undefined: no ID register; IDCODE opcode decodes as BYPASS; reset IR=BYPASS.

Structure
REQ-031 Package tap_pkg SHALL hold the TAP state enum, opcode constants, and DR widths (BSR 10, BIST_DATA 16, ID 32).
REQ-032 Sub-module tap_fsm SHALL contain the 16-state FSM (inputs TCK, TRST, TMS; output state); tap_controller holds IR, DRs, decode.

Verification
REQ-033 TRST=0 then TMS=1 x5 -> TLR=1, IR reset value, TDO=0.
REQ-034 Load IR=GETTEST, shift TDI=10'h2A5 LSB-first, go to Update-DR -> BSR=10'h2A5 on the same cycle UPDATEDR=1, exactly one pulse.
REQ-035 With TAP_IDCODE_EN, reset then shift 32 DR bits -> TDO returns 32'h1000_0001 LSB-first; without it -> single 0 then TDI delayed one cycle.
REQ-036 IR=READBIST, BIST_DATA=16'hFFFF at Capture-DR -> 16 ones on TDO; BIST_DATA changing during Shift-DR does not alter output.
REQ-037 IR=RUNBIST -> RUNBIST_SELECT=1 from cycle after Update-IR; TMS=1 x5 -> RUNBIST_SELECT=0, TLR=1.
REQ-038 TRST pulsed after 5 of 10 GETTEST shift bits -> BSR=0, no UPDATEDR pulse.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: FSM state encoding, instruction opcodes and DR widths.
// TAP_IDCODE_EN enables the IDCODE instruction and its 32-bit ID register.
package tap_pkg;

  typedef enum logic [3:0] {
    ST_EXIT2_DR = 4'h0,
    ST_EXIT1_DR = 4'h1,
    ST_SHIFT_DR = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EXIT2_IR = 4'h8,
    ST_EXIT1_IR = 4'h9,
    ST_SHIFT_IR = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_GETTEST,
    SEL_READBIST
  } dr_sel_e;

  localparam logic [3:0] OP_BYPASS   = 4'hF;
  localparam logic [3:0] OP_IDCODE   = 4'h1;
  localparam logic [3:0] OP_GETTEST  = 4'h2;
  localparam logic [3:0] OP_RUNBIST  = 4'h3;
  localparam logic [3:0] OP_READBIST = 4'h4;

  localparam int BSR_W  = 10;
  localparam int BIST_W = 16;
  localparam int ID_W   = 32;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 16-state TAP controller state machine, advanced by TMS on posedge TCK.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) r_state <= ST_TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_TLR:      w_next = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      w_next = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   w_next = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   w_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: w_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: w_next = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: w_next = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   w_next = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   w_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: w_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: w_next = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: w_next = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = TMS ? ST_SEL_DR   : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: instruction register, data registers, decode and TDO mux.
// TAP_IDCODE_EN adds the IDCODE instruction, 32-bit ID register and IDCODE reset IR.
module tap_controller
  import tap_pkg::*;
#(
  parameter int              IR_WIDTH     = 4,
  parameter logic [ID_W-1:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  input  logic [BIST_W-1:0] BIST_DATA,
  output logic              TLR,
  output logic              UPDATEDR,
  output logic              GETTEST_SELECT,
  output logic              RUNBIST_SELECT,
  output logic [BSR_W-1:0]  BSR
);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = {IR_WIDTH{1'b1}};
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  tap_state_e          w_state;
  dr_sel_e             w_sel;
  logic                w_ir_rst;
  logic                w_to_upd_dr;
  logic                w_tdo;

  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir;
  logic                r_byp;
  logic [BSR_W-1:0]    r_bsr_sr;
  logic [BSR_W-1:0]    r_bsr;
  logic [BIST_W-1:0]   r_bist_sr;
`ifdef TAP_IDCODE_EN
  logic [ID_W-1:0]     r_id_sr;
`endif

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (w_state)
  );

  // The only TMS-driven entry into Test-Logic-Reset is from Select-IR-Scan.
  assign w_ir_rst    = (w_state == ST_TLR) || ((w_state == ST_SEL_IR) && TMS);
  assign w_to_upd_dr = ((w_state == ST_EXIT1_DR) || (w_state == ST_EXIT2_DR)) && TMS;

  always_comb begin
    w_sel = SEL_BYPASS;
`ifdef TAP_IDCODE_EN
    if (r_ir == IR_WIDTH'(OP_IDCODE))   w_sel = SEL_IDCODE;
`endif
    if (r_ir == IR_WIDTH'(OP_GETTEST))  w_sel = SEL_GETTEST;
    if (r_ir == IR_WIDTH'(OP_READBIST)) w_sel = SEL_READBIST;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir_sr <= '0;
      r_ir    <= IR_RESET;
    end else begin
      if (w_state == ST_CAP_IR)        r_ir_sr <= IR_CAPTURE;
      else if (w_state == ST_SHIFT_IR) r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
      if (w_ir_rst)                    r_ir    <= IR_RESET;
      else if (w_state == ST_UPD_IR)   r_ir    <= r_ir_sr;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_byp     <= 1'b0;
      r_bsr_sr  <= '0;
      r_bist_sr <= '0;
    end else begin
      if (w_sel == SEL_BYPASS) begin
        if (w_state == ST_CAP_DR)        r_byp <= 1'b0;
        else if (w_state == ST_SHIFT_DR) r_byp <= TDI;
      end
      if (w_sel == SEL_GETTEST) begin
        if (w_state == ST_CAP_DR)        r_bsr_sr <= r_bsr;
        else if (w_state == ST_SHIFT_DR) r_bsr_sr <= {TDI, r_bsr_sr[BSR_W-1:1]};
      end
      if (w_sel == SEL_READBIST) begin
        if (w_state == ST_CAP_DR)        r_bist_sr <= BIST_DATA;
        else if (w_state == ST_SHIFT_DR) r_bist_sr <= {TDI, r_bist_sr[BIST_W-1:1]};
      end
    end
  end

`ifdef TAP_IDCODE_EN
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_id_sr <= '0;
    end else if (w_sel == SEL_IDCODE) begin
      if (w_state == ST_CAP_DR)        r_id_sr <= IDCODE_VALUE;
      else if (w_state == ST_SHIFT_DR) r_id_sr <= {TDI, r_id_sr[ID_W-1:1]};
    end
  end
`endif

  // BSR updates on the edge into Update-DR so it is already new while UPDATEDR is high.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)                                     r_bsr <= '0;
    else if (w_to_upd_dr && (w_sel == SEL_GETTEST)) r_bsr <= r_bsr_sr;
  end

  always_comb begin
    w_tdo = 1'b0;
    if (w_state == ST_SHIFT_IR) begin
      w_tdo = r_ir_sr[0];
    end else if (w_state == ST_SHIFT_DR) begin
      unique case (w_sel)
        SEL_GETTEST:  w_tdo = r_bsr_sr[0];
        SEL_READBIST: w_tdo = r_bist_sr[0];
`ifdef TAP_IDCODE_EN
        SEL_IDCODE:   w_tdo = r_id_sr[0];
`endif
        default:      w_tdo = r_byp;
      endcase
    end
  end

  assign TDO            = w_tdo;
  assign TLR            = (w_state == ST_TLR);
  assign UPDATEDR       = (w_state == ST_UPD_DR);
  assign GETTEST_SELECT = (r_ir == IR_WIDTH'(OP_GETTEST));
  assign RUNBIST_SELECT = (r_ir == IR_WIDTH'(OP_RUNBIST));
  assign BSR            = r_bsr;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller; follows TAP_IDCODE_EN to pick the expected reset IR.
module tb_tap_controller;

  logic        TCK = 1'b0;
  logic        TRST = 1'b0;
  logic        TMS = 1'b1;
  logic        TDI = 1'b0;
  logic [15:0] BIST_DATA = 16'h0000;
  logic        TDO;
  logic        TLR;
  logic        UPDATEDR;
  logic        GETTEST_SELECT;
  logic        RUNBIST_SELECT;
  logic [9:0]  BSR;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

  logic [9:0] bsr_model;

  tap_controller #(.IR_WIDTH(4), .IDCODE_VALUE(32'h1000_0001)) dut (
    .TCK            (TCK),
    .TRST           (TRST),
    .TMS            (TMS),
    .TDI            (TDI),
    .TDO            (TDO),
    .BIST_DATA      (BIST_DATA),
    .TLR            (TLR),
    .UPDATEDR       (UPDATEDR),
    .GETTEST_SELECT (GETTEST_SELECT),
    .RUNBIST_SELECT (RUNBIST_SELECT),
    .BSR            (BSR)
  );

  always #5 TCK = ~TCK;

  always @(negedge TCK) if (UPDATEDR === 1'b1) upd_cnt++;

  // Length of the data register each instruction places between TDI and TDO.
  function automatic int dr_width(input logic [3:0] op);
    case (op)
      4'h2: return 10;
      4'h4: return 16;
`ifdef TAP_IDCODE_EN
      4'h1: return 32;
`endif
      default: return 1;
    endcase
  endfunction

  // A scan of n bits returns the captured word LSB-first, then the TDI bits delayed by the DR length.
  function automatic logic [31:0] expect_out(input int n, input int width,
                                             input logic [31:0] cap, input logic [31:0] din);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = (i < width) ? cap[i] : din[i - width];
    return r;
  endfunction

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From Run-Test/Idle: load an opcode, check the captured IR pattern, return to Run-Test/Idle.
  task automatic load_ir(input logic [3:0] op);
    logic [3:0] cap;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = TDO;
      step(i == 3, op[i]);
    end
    n_checks++;
    if (cap !== 4'b0001) begin
      n_fail++;
      $display("FAIL ir_capture: got %b expected 0001", cap);
    end
    step(1, 0);
    step(0, 0);
  endtask

  // From Run-Test/Idle: full DR scan with optional pause, ending in Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [31:0] din, input int pause_at,
                         input bit scramble, output logic [31:0] dout,
                         output logic [9:0] bsr_upd, output logic upd_lvl, output int pulses);
    int c0;
    step(1, 0); step(0, 0); step(0, 0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      if (scramble) BIST_DATA = 16'($urandom);
      step((i == n - 1) || (pause_at > 0 && i == pause_at - 1), din[i]);
      if (pause_at > 0 && i == pause_at - 1 && i != n - 1) begin
        step(0, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end
    end
    c0 = upd_cnt;
    step(1, 0);
    bsr_upd = BSR;
    upd_lvl = UPDATEDR;
    step(0, 0);
    pulses = upd_cnt - c0;
  endtask

  task automatic test_reset();
    TRST = 1'b0;
    TMS  = 1'b1;
    #12;
    n_checks++;
    if ({TLR, UPDATEDR, GETTEST_SELECT, RUNBIST_SELECT, TDO} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {TLR, UPDATEDR, GETTEST_SELECT, RUNBIST_SELECT, TDO});
    end
    n_checks++;
    if (BSR !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_bsr: got %h expected 000", BSR);
    end
    TRST = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0);
    n_checks++;
    if (TLR !== 1'b1 || TDO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tms5: got TLR=%b TDO=%b expected TLR=1 TDO=0", TLR, TDO);
    end
    step(0, 0);
    n_checks++;
    if (TLR !== 1'b0 || TDO !== 1'b0) begin
      n_fail++;
      $display("FAIL rti_idle: got TLR=%b TDO=%b expected TLR=0 TDO=0", TLR, TDO);
    end
    bsr_model = '0;
  endtask

  task automatic test_reset_ir();
    logic [31:0] din, dout, exp;
    logic [9:0]  b;
    logic        u;
    int          p;
    din = $urandom;
`ifdef TAP_IDCODE_EN
    exp = expect_out(32, 32, 32'h1000_0001, din);
`else
    exp = expect_out(32, 1, 32'h0, din);
`endif
    scan_dr(32, din, 0, 0, dout, b, u, p);
    n_checks++;
    if (dout !== exp) begin
      n_fail++;
      $display("FAIL reset_ir_dr: got %h expected %h", dout, exp);
    end
  endtask

  task automatic test_gettest();
    logic [31:0] din, dout, exp;
    logic [9:0]  b;
    logic        u;
    int          p;
    load_ir(4'h2);
    n_checks++;
    if (GETTEST_SELECT !== 1'b1 || RUNBIST_SELECT !== 1'b0) begin
      n_fail++;
      $display("FAIL gettest_select: got G=%b R=%b expected G=1 R=0", GETTEST_SELECT, RUNBIST_SELECT);
    end
    for (int k = 0; k < 5; k++) begin
      din = (k == 0) ? 32'h2A5 : {22'h0, 10'($urandom)};
      exp = expect_out(10, 10, {22'h0, bsr_model}, din);
      scan_dr(10, din, (k == 4) ? 5 : 0, 0, dout, b, u, p);
      n_checks++;
      if (dout !== exp) begin
        n_fail++;
        $display("FAIL gettest_capture[%0d]: got %h expected %h", k, dout, exp);
      end
      n_checks++;
      if (b !== din[9:0] || u !== 1'b1 || p != 1) begin
        n_fail++;
        $display("FAIL gettest_update[%0d]: got BSR=%h UPD=%b pulses=%0d expected BSR=%h UPD=1 pulses=1",
                 k, b, u, p, din[9:0]);
      end
      bsr_model = din[9:0];
    end
  endtask

  task automatic test_readbist();
    logic [31:0] dout, exp;
    logic [15:0] cap;
    logic [9:0]  b;
    logic        u;
    int          p;
    load_ir(4'h4);
    for (int k = 0; k < 3; k++) begin
      cap = (k == 0) ? 16'hFFFF : 16'($urandom);
      BIST_DATA = cap;
      exp = expect_out(16, 16, {16'h0, cap}, 32'h0);
      scan_dr(16, 32'h0, 0, 1, dout, b, u, p);
      n_checks++;
      if (dout !== exp) begin
        n_fail++;
        $display("FAIL readbist[%0d]: got %h expected %h", k, dout, exp);
      end
      n_checks++;
      if (b !== bsr_model || u !== 1'b1 || p != 1) begin
        n_fail++;
        $display("FAIL readbist_upd[%0d]: got BSR=%h UPD=%b pulses=%0d expected BSR=%h UPD=1 pulses=1",
                 k, b, u, p, bsr_model);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] din, dout, exp;
    logic [3:0]  op;
    logic [9:0]  b;
    logic        u;
    int          p, n;
    for (int k = 0; k < 4; k++) begin
      op = 4'hF;
      for (int t = 0; t < 50 && k > 0; t++) begin
        op = 4'($urandom_range(0, 15));
        if (op != 4'h2 && op != 4'h3 && op != 4'h4) break;
      end
      if (op == 4'h2 || op == 4'h3 || op == 4'h4) op = 4'h0;
      load_ir(op);
      n = $urandom_range(3, 32);
      din = $urandom;
      exp = expect_out(n, dr_width(op), 32'h1000_0001 & {32{dr_width(op) == 32}}, din);
      scan_dr(n, din, 0, 0, dout, b, u, p);
      n_checks++;
      if (dout !== exp || b !== bsr_model) begin
        n_fail++;
        $display("FAIL bypass_op%h: got %h BSR=%h expected %h BSR=%h", op, dout, b, exp, bsr_model);
      end
    end
  endtask

  task automatic test_runbist();
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, OP_BIT(i));
    step(1, 0);
    n_checks++;
    if (RUNBIST_SELECT !== 1'b0) begin
      n_fail++;
      $display("FAIL runbist_early: got %b expected 0", RUNBIST_SELECT);
    end
    step(0, 0);
    n_checks++;
    if (RUNBIST_SELECT !== 1'b1 || GETTEST_SELECT !== 1'b0) begin
      n_fail++;
      $display("FAIL runbist_select: got R=%b G=%b expected R=1 G=0", RUNBIST_SELECT, GETTEST_SELECT);
    end
    for (int i = 0; i < 5; i++) step(1, 0);
    n_checks++;
    if (TLR !== 1'b1 || RUNBIST_SELECT !== 1'b0 || BSR !== bsr_model) begin
      n_fail++;
      $display("FAIL runbist_tlr: got TLR=%b R=%b BSR=%h expected TLR=1 R=0 BSR=%h",
               TLR, RUNBIST_SELECT, BSR, bsr_model);
    end
    step(0, 0);
  endtask

  function automatic logic OP_BIT(input int i);
    logic [3:0] op;
    op = 4'h3;
    return op[i];
  endfunction

  task automatic test_trst_abort();
    logic [31:0] dout;
    logic [9:0]  b;
    logic        u;
    int          p, c0;
    load_ir(4'h2);
    scan_dr(10, 32'h155, 0, 0, dout, b, u, p);
    bsr_model = 10'h155;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    c0 = upd_cnt;
    TRST = 1'b0;
    #2;
    n_checks++;
    if (BSR !== 10'h000 || TLR !== 1'b1 || TDO !== 1'b0 || GETTEST_SELECT !== 1'b0) begin
      n_fail++;
      $display("FAIL trst_abort: got BSR=%h TLR=%b TDO=%b G=%b expected BSR=000 TLR=1 TDO=0 G=0",
               BSR, TLR, TDO, GETTEST_SELECT);
    end
    @(negedge TCK);
    TRST = 1'b1;
    step(1, 1); step(1, 1); step(1, 1);
    n_checks++;
    if (upd_cnt != c0 || BSR !== 10'h000) begin
      n_fail++;
      $display("FAIL trst_no_update: got pulses=%0d BSR=%h expected pulses=0 BSR=000", upd_cnt - c0, BSR);
    end
    bsr_model = '0;
    step(0, 0);
  endtask

  task automatic test_random_walk();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom));
      for (int i = 0; i < 5; i++) step(1, 0);
      n_checks++;
      if (TLR !== 1'b1 || TDO !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_tlr[%0d]: got TLR=%b TDO=%b expected TLR=1 TDO=0", k, TLR, TDO);
      end
    end
    step(0, 0);
  endtask

  initial begin
    test_reset();
    test_reset_ir();
    test_gettest();
    test_readbist();
    test_bypass();
    test_runbist();
    test_trst_abort();
    test_random_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
